// File: rtl/t_counter_ctrl.sv
// Run-to-limit sequencer driving a WIDTH-bit T flip-flop up/down counter bank.
// Define TCTRL_WRAP_FLAG_EN to add the sticky wrap output.
module t_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
`ifdef TCTRL_WRAP_FLAG_EN
    output logic             wrap,
`endif
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_UP    = 2'b00;
    localparam logic [1:0] OP_DOWN  = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [1:0]       r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_tvec;
    logic             w_accept;
    logic             w_halt;

    assign cmd_ready = (r_state != S_DONE);
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_halt    = w_accept & cmd_op[1];
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign q         = r_q;
    assign t_vec     = w_tvec;

    // Ripple-style toggle enables: bit i flips when all lower bits are at the carry/borrow value.
    always_comb begin
        logic w_c1;
        logic w_c0;
        w_tvec = '0;
        w_c1   = 1'b1;
        w_c0   = 1'b1;
        if (r_state == S_RUN && !w_halt && r_q != r_limit) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_tvec[i] = r_dir ? w_c0 : w_c1;
                w_c1      = w_c1 & r_q[i];
                w_c0      = w_c0 & ~r_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_limit <= '0;
            r_q     <= '0;
        end else begin
            r_q <= r_q ^ w_tvec;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (cmd_op)
                            OP_UP, OP_DOWN: begin
                                r_state <= S_RUN;
                                r_dir   <= cmd_op[0];
                                r_limit <= cmd_limit;
                            end
                            OP_CLEAR: r_q <= '0;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        case (cmd_op)
                            OP_UP, OP_DOWN: begin
                                r_dir   <= cmd_op[0];
                                r_limit <= cmd_limit;
                            end
                            OP_STOP: r_state <= S_IDLE;
                            default: begin
                                r_state <= S_IDLE;
                                r_q     <= '0;
                            end
                        endcase
                    end else if (r_q == r_limit) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TCTRL_WRAP_FLAG_EN
    logic r_wrap;
    logic w_wrap_step;
    logic w_wrap_clr;

    assign w_wrap_step = (w_tvec != '0) & (r_dir ? (r_q == '0) : (&r_q));
    assign w_wrap_clr  = w_accept & (cmd_op != OP_STOP);
    assign wrap        = r_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap <= 1'b0;
        end else if (w_wrap_clr) begin
            r_wrap <= 1'b0;
        end else if (w_wrap_step) begin
            r_wrap <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_t_counter_ctrl.sv
// Directed bench for t_counter_ctrl (WIDTH=4) with hand-computed expectations.
module tb_t_counter_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_limit;
    logic [3:0] t_vec;
    logic [3:0] q;
    logic       busy;
    logic       done;
`ifdef TCTRL_WRAP_FLAG_EN
    logic       wrap;
`endif

    int n_chk;
    int n_pass;

    t_counter_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_limit (cmd_limit),
        .t_vec     (t_vec),
        .q         (q),
        .busy      (busy),
`ifdef TCTRL_WRAP_FLAG_EN
        .wrap      (wrap),
`endif
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] lim);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_limit = lim;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_limit = 4'd0;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_limit = 4'd0;
        step();
        step();
        chk("rst_q", q, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tvec", t_vec, 4'd0);
        rst = 1'b1;
        step();
        chk("ready_after_rst", cmd_ready, 1'b1);

        // 1: up to 5 from 0
        cmd(2'b00, 4'd5);
        chk("t1_busy_E", busy, 1'b1);
        chk("t1_q_E", q, 4'd0);
        chk("t1_tvec_E", t_vec, 4'b0001);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t1_q", q, 32'(k));
            chk("t1_busy", busy, 1'b1);
            chk("t1_done", done, 1'b0);
            if (k == 3) chk("t1_tvec_q3", t_vec, 4'b0111);
        end
        chk("t1_tvec_lim", t_vec, 4'd0);
        step();
        chk("t1_done_E6", done, 1'b1);
        chk("t1_busy_E6", busy, 1'b0);
        chk("t1_ready_E6", cmd_ready, 1'b0);
        chk("t1_q_E6", q, 4'd5);
        step();
        chk("t1_done_E7", done, 1'b0);
        chk("t1_ready_E7", cmd_ready, 1'b1);

        // 2: set q=1 then down to 14 through wrap
        cmd(2'b11, 4'd0);
        chk("t2_clr", q, 4'd0);
        cmd(2'b00, 4'd1);
        step();
        chk("t2_q1", q, 4'd1);
        step();
        step();
        cmd(2'b01, 4'd14);
        chk("t2_tvec_q1", t_vec, 4'b0001);
        step();
        chk("t2_q0", q, 4'd0);
        chk("t2_tvec_q0", t_vec, 4'b1111);
        step();
        chk("t2_q15", q, 4'd15);
`ifdef TCTRL_WRAP_FLAG_EN
        chk("t2_wrap", wrap, 1'b1);
`endif
        step();
        chk("t2_q14", q, 4'd14);
        chk("t2_done_early", done, 1'b0);
        step();
        chk("t2_done", done, 1'b1);
        step();

        // 3: stop at 3, then clear
        cmd(2'b11, 4'd0);
`ifdef TCTRL_WRAP_FLAG_EN
        chk("t3_wrap_clr", wrap, 1'b0);
`endif
        cmd(2'b00, 4'd9);
        step();
        step();
        step();
        chk("t3_q3", q, 4'd3);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        #1;
        chk("t3_tvec_stop", t_vec, 4'd0);
        step();
        cmd_valid = 1'b0;
        chk("t3_q_hold", q, 4'd3);
        chk("t3_busy", busy, 1'b0);
        step();
        chk("t3_q_hold2", q, 4'd3);
        chk("t3_no_done", done, 1'b0);
        cmd(2'b11, 4'd0);
        chk("t3_clr", q, 4'd0);

        // 4: start with limit equal to q
        cmd(2'b00, 4'd7);
        repeat (7) step();
        chk("t4_q7", q, 4'd7);
        step();
        step();
        cmd(2'b00, 4'd7);
        chk("t4_busy", busy, 1'b1);
        chk("t4_tvec", t_vec, 4'd0);
        step();
        chk("t4_done", done, 1'b1);
        chk("t4_q_stay", q, 4'd7);
        step();
        cmd(2'b01, 4'd5);
        chk("t4_restart", busy, 1'b1);
        step();
        chk("t4_q6", q, 4'd6);

        // 6: async reset mid-run at q=6
        #3;
        rst = 1'b0;
        #1;
        chk("t6_q", q, 4'd0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_tvec", t_vec, 4'd0);
`ifdef TCTRL_WRAP_FLAG_EN
        chk("t6_wrap", wrap, 1'b0);
`endif
        #1;
        rst = 1'b1;
        step();
        chk("t6_idle", busy, 1'b0);
        chk("t6_no_done", done, 1'b0);

        // 5: command held through DONE
        cmd(2'b00, 4'd1);
        step();
        step();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_limit = 4'd2;
        chk("t5_done", done, 1'b1);
        chk("t5_ready_lo", cmd_ready, 1'b0);
        step();
        chk("t5_idle", busy, 1'b0);
        chk("t5_ready_hi", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        chk("t5_accept", busy, 1'b1);
        chk("t5_q1", q, 4'd1);
        step();
        chk("t5_q2", q, 4'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
